// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces one quotient bit per cycle; quotient goes to LO and remainder to HI.
module ex_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             annul,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall_req,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVZERO,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   divisor_mag_q;
    logic               sign_q;
    logic               sign_r;

    logic [WIDTH-1:0]   dividend_mag;
    logic [WIDTH-1:0]   divisor_mag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               take;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    // Operand magnitudes; -0x80000000 wraps to itself, which is exactly the
    // unsigned magnitude we need for the overflow case.
    assign dividend_mag = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag  = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;

    // One restoring step: shift {r,q} left, subtract divisor when it fits.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, divisor_mag_q};
        take     = (shifted >= {1'b0, divisor_mag_q});
        rem_next = shifted[WIDTH-1:0];
        if (take) begin
            rem_next = diff[WIDTH-1:0];
        end
        quo_next = {quo_q[WIDTH-2:0], take};
    end

    // Stall drops in DONE so EX advances on the same edge that consumes ready.
    assign stall_req = start & ~annul & (state != DONE);

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            count         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            divisor_mag_q <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            quotient      <= '0;
            remainder     <= '0;
            ready         <= 1'b0;
        end else if (annul) begin
            state <= IDLE;
            ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        rem_q         <= '0;
                        divisor_mag_q <= divisor_mag;
                        sign_q        <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r        <= signed_div & dividend[WIDTH-1];
                        count         <= '0;
                        if (divisor == '0) begin
                            // Keep the raw dividend: it becomes the remainder.
                            quo_q <= dividend;
                            state <= DIVZERO;
                        end else begin
                            quo_q <= dividend_mag;
                            state <= BUSY;
                        end
                    end
                end
                DIVZERO: begin
                    quotient  <= '1;
                    remainder <= quo_q;
                    ready     <= 1'b1;
                    state     <= DONE;
                end
                BUSY: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        quotient  <= sign_q ? -quo_next : quo_next;
                        remainder <= sign_r ? -rem_next : rem_next;
                        ready     <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed corner cases plus random
// DIV/DIVU operations compared against an arithmetic reference model.
module tb_ex_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        annul;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        stall_req;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int          checks;
    int          failures;
    logic [31:0] last_q;
    logic [31:0] last_r;

    ex_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .start      (start),
        .annul      (annul),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .stall_req  (stall_req),
        .ready      (ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of DIV/DIVU: truncating division, remainder takes
    // the dividend's sign; divide-by-zero gives all ones and the raw dividend.
    function automatic void model(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called at a falling edge; this falling edge is cycle 0 of the request.
    task automatic do_op(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input int chg_at = -1, input int drop_at = -1);
        logic [31:0] eq;
        logic [31:0] er;
        int          elat;
        int          cyc;
        model(sd, a, b, eq, er);
        elat       = (b == 32'd0) ? 2 : 33;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        annul      = 1'b0;
        #1;
        check({tag, "_stall_c0"}, stall_req, 1'b1);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ready !== 1'b1) begin
                check({tag, "_stall_busy"}, stall_req, start);
            end
            if (cyc == chg_at) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (cyc == drop_at) begin
                start = 1'b0;
            end
        end
        check({tag, "_latency"}, cyc, elat);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_stall_done"}, stall_req, 1'b0);
        if (start) begin
            @(negedge clk);
            check({tag, "_ready_held"}, ready, 1'b1);
            start = 1'b0;
        end
        @(negedge clk);
        check({tag, "_ready_low"}, ready, 1'b0);
        check({tag, "_q_hold"}, quotient, eq);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        last_q     = '0;
        last_r     = '0;

        repeat (2) @(negedge clk);
        check("rst_quotient", quotient, 32'h0);
        check("rst_remainder", remainder, 32'h0);
        check("rst_ready", ready, 1'b0);
        check("rst_stall_idle", stall_req, 1'b0);
        start = 1'b1;
        #1;
        check("rst_stall_follows_start", stall_req, 1'b1);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        check("divu_100_7_const_q", last_q, 32'h0000_000E);
        check("divu_100_7_const_r", last_r, 32'h0000_0002);
        do_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
        do_op("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9);
        do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const_q", last_q, 32'h8000_0000);
        do_op("divu_by0", 1'b0, 32'h1234_5678, 32'd0);
        do_op("div_by0_neg", 1'b1, 32'h8000_0005, 32'd0);
        do_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        do_op("divu_small_big", 1'b0, 32'd5, 32'hFFFF_FFFF);

        // Annul in the middle of BUSY: back to IDLE, old results retained.
        signed_div = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        start      = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("annul_ready_busy", ready, 1'b0);
        end
        annul = 1'b1;
        #1;
        check("annul_stall", stall_req, 1'b0);
        @(negedge clk);
        check("annul_ready", ready, 1'b0);
        check("annul_q_retained", quotient, last_q);
        check("annul_r_retained", remainder, last_r);
        annul = 1'b0;
        do_op("annul_restart_9_3", 1'b0, 32'd9, 32'd3);

        // Asynchronous reset in the middle of BUSY.
        signed_div = 1'b1;
        dividend   = 32'hFFFF_CFC7;
        divisor    = 32'd17;
        start      = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_quotient", quotient, 32'h0);
        check("midrst_remainder", remainder, 32'h0);
        check("midrst_ready", ready, 1'b0);
        check("midrst_stall", stall_req, 1'b1);
        start = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        last_q = '0;
        last_r = '0;
        @(negedge clk);
        check("midrst_idle_ready", ready, 1'b0);
        do_op("after_rst", 1'b1, 32'hFFFF_CFC7, 32'd17);

        // Operand changes while BUSY, and start withdrawn while BUSY.
        do_op("opchg_signed", 1'b1, 32'hFFFF_C000, 32'd13, 2, -1);
        do_op("opchg_unsigned", 1'b0, 32'hCAFE_F00D, 32'h0000_0101, 20, -1);
        do_op("drop_busy", 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, -1, 5);
        do_op("drop_divzero", 1'b1, 32'hFFFF_FFF0, 32'd0, -1, 1);

        for (int i = 0; i < 24; i++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = -32'($urandom_range(1, 15));
            endcase
            do_op("random", sd, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
